// File: rtl/dmg_pkg.sv
// Shared DMG cartridge-ROM definitions: default ROM geometry and the read-owner tag
// carried alongside each in-flight PROM read.
package dmg_pkg;

  localparam int ROM_ADDR_W = 15;
  localparam int ROM_DATA_W = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } rom_owner_t;

endpackage

// File: rtl/rom_tag_pipe.sv
// Owner-tag delay line matching the PROM read latency; one tag enters every cycle
// so the tag leaving the end always names the owner of the byte on rom_data.
module rom_tag_pipe
  import dmg_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  rom_owner_t tag_in,
  output rom_owner_t tag_out
);

  rom_owner_t stage_r [DEPTH];

  // Shift register; synchronous clear discards every in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= OWN_NONE;
      end
    end else begin
      stage_r[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign tag_out = stage_r[DEPTH-1];

endmodule

// File: rtl/cart_rom_arbiter.sv
// Shares the single-port cartridge PROM between the CPU and OAM DMA: one grant per
// cycle, DMA preferred but the CPU is guaranteed a slot after MAX_WAIT losses.
module cart_rom_arbiter
  import dmg_pkg::*;
#(
  parameter int ADDR_W   = ROM_ADDR_W,
  parameter int DATA_W   = ROM_DATA_W,
  parameter int ROM_LAT  = 1,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0]        wait_ctr_r;
  logic [ADDR_W-1:0] addr_hold_r;
  logic              cpu_win_s;
  logic              dma_win_s;
  rom_owner_t        push_tag_s;
  rom_owner_t        ret_tag_s;

  // Grant decision: DMA wins ties until the CPU has waited MAX_WAIT cycles.
  always_comb begin
    cpu_win_s = 1'b0;
    dma_win_s = 1'b0;
    if (rst) begin
      cpu_win_s = 1'b0;
      dma_win_s = 1'b0;
    end else if (cpu_req && (!dma_req || (wait_ctr_r == MAX_WAIT_C))) begin
      cpu_win_s = 1'b1;
    end else if (dma_req) begin
      dma_win_s = 1'b1;
    end else begin
      cpu_win_s = 1'b0;
      dma_win_s = 1'b0;
    end
  end

  assign cpu_gnt = cpu_win_s;
  assign dma_gnt = dma_win_s;
  assign rom_ce  = cpu_win_s | dma_win_s;

  // PROM address mux and owner tag for this cycle; idle cycles replay the last address.
  always_comb begin
    rom_addr   = addr_hold_r;
    push_tag_s = OWN_NONE;
    if (rst) begin
      rom_addr = {ADDR_W{1'b0}};
    end else if (cpu_win_s) begin
      rom_addr   = cpu_addr;
      push_tag_s = OWN_CPU;
    end else if (dma_win_s) begin
      rom_addr   = dma_addr;
      push_tag_s = OWN_DMA;
    end else begin
      rom_addr   = addr_hold_r;
      push_tag_s = OWN_NONE;
    end
  end

  // CPU starvation counter and held copy of the last granted address.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_ctr_r  <= 4'd0;
      addr_hold_r <= {ADDR_W{1'b0}};
    end else begin
      if (rom_ce) begin
        addr_hold_r <= rom_addr;
      end
      if (!cpu_req || cpu_win_s) begin
        wait_ctr_r <= 4'd0;
      end else if (wait_ctr_r < MAX_WAIT_C) begin
        wait_ctr_r <= wait_ctr_r + 4'd1;
      end
    end
  end

  rom_tag_pipe #(
    .DEPTH (ROM_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (push_tag_s),
    .tag_out (ret_tag_s)
  );

  // Return demux: only the owning port sees rom_data, everything else reads zero.
  always_comb begin
    cpu_rvalid = 1'b0;
    dma_rvalid = 1'b0;
    cpu_rdata  = {DATA_W{1'b0}};
    dma_rdata  = {DATA_W{1'b0}};
    if (rst) begin
      cpu_rvalid = 1'b0;
      dma_rvalid = 1'b0;
    end else begin
      case (ret_tag_s)
        OWN_CPU: begin
          cpu_rvalid = 1'b1;
          cpu_rdata  = rom_data;
        end
        OWN_DMA: begin
          dma_rvalid = 1'b1;
          dma_rdata  = rom_data;
        end
        default: begin
          cpu_rvalid = 1'b0;
          dma_rvalid = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cart_rom_arbiter.sv
// Directed bench: a ROM_LAT=1 and a ROM_LAT=3 arbiter share the same requesters,
// each backed by a behavioural PROM whose byte is a fixed function of the address.
module tb_cart_rom_arbiter;

  localparam int AW = 15;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          cpu_req, dma_req;
  logic [AW-1:0] cpu_addr, dma_addr;

  logic          cpu_gnt1, cpu_rvalid1, dma_gnt1, dma_rvalid1, rom_ce1;
  logic [DW-1:0] cpu_rdata1, dma_rdata1, rom_data1;
  logic [AW-1:0] rom_addr1;
  logic          cpu_gnt3, cpu_rvalid3, dma_gnt3, dma_rvalid3, rom_ce3;
  logic [DW-1:0] cpu_rdata3, dma_rdata3, rom_data3;
  logic [AW-1:0] rom_addr3;
  logic [DW-1:0] d3 [3];

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] rom_f(input logic [14:0] a);
    return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h5A;
  endfunction

  always @(posedge clk) rom_data1 <= rom_f(rom_addr1);
  always @(posedge clk) begin
    d3[0] <= rom_f(rom_addr3);
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end
  assign rom_data3 = d3[2];

  cart_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1), .MAX_WAIT(3)) dut1 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt1),
    .cpu_rvalid(cpu_rvalid1), .cpu_rdata(cpu_rdata1),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_gnt(dma_gnt1),
    .dma_rvalid(dma_rvalid1), .dma_rdata(dma_rdata1),
    .rom_ce(rom_ce1), .rom_addr(rom_addr1), .rom_data(rom_data1)
  );

  cart_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(3), .MAX_WAIT(3)) dut3 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt3),
    .cpu_rvalid(cpu_rvalid3), .cpu_rdata(cpu_rdata3),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_gnt(dma_gnt3),
    .dma_rvalid(dma_rvalid3), .dma_rdata(dma_rdata3),
    .rom_ce(rom_ce3), .rom_addr(rom_addr3), .rom_data(rom_data3)
  );

  task automatic test_reset();
    rst = 1'b1; cpu_req = 1'b1; dma_req = 1'b1;
    cpu_addr = 15'h0123; dma_addr = 15'h4567;
    repeat (2) begin
      @(negedge clk); #1;
      checks++;
      if ({cpu_gnt1, dma_gnt1, rom_ce1, cpu_rvalid1, dma_rvalid1} !== 5'b00000) begin
        errors++;
        $display("FAIL reset_ctl1 got %b want 00000", {cpu_gnt1, dma_gnt1, rom_ce1, cpu_rvalid1, dma_rvalid1});
      end
      checks++;
      if ({rom_addr1, cpu_rdata1, dma_rdata1} !== 31'h0) begin
        errors++;
        $display("FAIL reset_data1 got addr %h cd %h dd %h want 0", rom_addr1, cpu_rdata1, dma_rdata1);
      end
      checks++;
      if ({cpu_gnt3, dma_gnt3, rom_ce3, cpu_rvalid3, dma_rvalid3} !== 5'b00000) begin
        errors++;
        $display("FAIL reset_ctl3 got %b want 00000", {cpu_gnt3, dma_gnt3, rom_ce3, cpu_rvalid3, dma_rvalid3});
      end
    end
    @(negedge clk);
    rst = 1'b0; cpu_req = 1'b0; dma_req = 1'b0; #1;
    checks++;
    if ({rom_ce1, rom_addr1, cpu_rvalid1, dma_rvalid1} !== 18'h0) begin
      errors++;
      $display("FAIL post_reset got ce %b addr %h cv %b dv %b want 0", rom_ce1, rom_addr1, cpu_rvalid1, dma_rvalid1);
    end
  endtask

  task automatic test_cpu_single();
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 15'h0100; #1;
    checks++;
    if ({cpu_gnt1, dma_gnt1, rom_ce1} !== 3'b101) begin
      errors++;
      $display("FAIL cpu_single_gnt got %b want 101", {cpu_gnt1, dma_gnt1, rom_ce1});
    end
    checks++;
    if (rom_addr1 !== 15'h0100) begin
      errors++;
      $display("FAIL cpu_single_addr got %h want 0100", rom_addr1);
    end
    @(negedge clk);
    cpu_req = 1'b0; #1;
    checks++;
    if (cpu_rvalid1 !== 1'b1 || cpu_rdata1 !== rom_f(15'h0100)) begin
      errors++;
      $display("FAIL cpu_single_ret got v %b d %h want v 1 d %h", cpu_rvalid1, cpu_rdata1, rom_f(15'h0100));
    end
    checks++;
    if (dma_rvalid1 !== 1'b0 || dma_rdata1 !== 8'h00) begin
      errors++;
      $display("FAIL cpu_single_dma got v %b d %h want 0", dma_rvalid1, dma_rdata1);
    end
    checks++;
    if (rom_ce1 !== 1'b0 || rom_addr1 !== 15'h0100) begin
      errors++;
      $display("FAIL cpu_single_hold got ce %b addr %h want ce 0 addr 0100", rom_ce1, rom_addr1);
    end
    @(negedge clk); #1;
    checks++;
    if (cpu_rvalid1 !== 1'b0 || cpu_rdata1 !== 8'h00) begin
      errors++;
      $display("FAIL cpu_single_idle got v %b d %h want 0", cpu_rvalid1, cpu_rdata1);
    end
  endtask

  task automatic test_contend();
    int            prev_own = 0;
    logic [14:0]   prev_addr = 15'h0;
    logic [14:0]   next_dma = 15'h4000;
    logic          exp_cpu;
    logic [17:0]   exp_ret;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      cpu_req = (i < 16); cpu_addr = 15'h0150;
      dma_req = (i < 16); dma_addr = next_dma; #1;
      exp_ret = {prev_own == 1, prev_own == 2,
                 (prev_own == 1) ? rom_f(prev_addr) : 8'h00,
                 (prev_own == 2) ? rom_f(prev_addr) : 8'h00};
      checks++;
      if ({cpu_rvalid1, dma_rvalid1, cpu_rdata1, dma_rdata1} !== exp_ret) begin
        errors++;
        $display("FAIL contend_ret[%0d] got %h want %h", i, {cpu_rvalid1, dma_rvalid1, cpu_rdata1, dma_rdata1}, exp_ret);
      end
      if (i < 16) begin
        exp_cpu = ((i % 4) == 3);
        checks++;
        if ({cpu_gnt1, dma_gnt1} !== {exp_cpu, !exp_cpu}) begin
          errors++;
          $display("FAIL contend_gnt[%0d] got %b want %b", i, {cpu_gnt1, dma_gnt1}, {exp_cpu, !exp_cpu});
        end
        prev_own  = exp_cpu ? 1 : 2;
        prev_addr = exp_cpu ? 15'h0150 : next_dma;
        if (!exp_cpu) next_dma = next_dma + 15'd1;
      end
    end
  endtask

  task automatic test_dma_stream();
    int          gnt_cnt = 0;
    int          rv_cnt = 0;
    logic [14:0] a;
    cpu_req = 1'b0; cpu_addr = 15'h0000;
    for (int i = 0; i <= 160; i++) begin
      @(negedge clk);
      a = 15'h4000 + 15'(i);
      dma_req = (i < 160); dma_addr = a; #1;
      if (dma_gnt1 === 1'b1) gnt_cnt++;
      if (dma_rvalid1 === 1'b1) rv_cnt++;
      if (i < 160) begin
        checks++;
        if (dma_gnt1 !== 1'b1 || rom_addr1 !== a) begin
          errors++;
          $display("FAIL stream_gnt[%0d] got g %b addr %h want g 1 addr %h", i, dma_gnt1, rom_addr1, a);
        end
      end
      if (i > 0) begin
        checks++;
        if (dma_rvalid1 !== 1'b1 || dma_rdata1 !== rom_f(a - 15'd1) || cpu_rvalid1 !== 1'b0) begin
          errors++;
          $display("FAIL stream_ret[%0d] got v %b d %h cv %b want v 1 d %h cv 0", i, dma_rvalid1, dma_rdata1, cpu_rvalid1, rom_f(a - 15'd1));
        end
      end
    end
    checks++;
    if (gnt_cnt != 160 || rv_cnt != 160) begin
      errors++;
      $display("FAIL stream_count got gnt %0d rv %0d want 160 160", gnt_cnt, rv_cnt);
    end
  endtask

  task automatic test_cpu_drop();
    bit          cr [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    bit          eg [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [14:0] next_dma = 15'h4200;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      cpu_req = cr[i]; cpu_addr = (i < 2) ? 15'h0333 : 15'h0777;
      dma_req = 1'b1; dma_addr = next_dma; #1;
      checks++;
      if ({cpu_gnt1, dma_gnt1, cpu_rvalid1} !== {eg[i], !eg[i], 1'b0}) begin
        errors++;
        $display("FAIL drop_gnt[%0d] got %b want %b", i, {cpu_gnt1, dma_gnt1, cpu_rvalid1}, {eg[i], !eg[i], 1'b0});
      end
      if (!eg[i]) next_dma = next_dma + 15'd1;
    end
    @(negedge clk);
    cpu_req = 1'b0; dma_req = 1'b0; #1;
    checks++;
    if (cpu_rvalid1 !== 1'b1 || cpu_rdata1 !== rom_f(15'h0777)) begin
      errors++;
      $display("FAIL drop_ret got v %b d %h want v 1 d %h", cpu_rvalid1, cpu_rdata1, rom_f(15'h0777));
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    dma_req = 1'b1; dma_addr = 15'h4ABC; cpu_req = 1'b0; #1;
    checks++;
    if ({dma_gnt1, dma_gnt3} !== 2'b11) begin
      errors++;
      $display("FAIL rmid_gnt got %b want 11", {dma_gnt1, dma_gnt3});
    end
    @(negedge clk);
    rst = 1'b1; dma_req = 1'b0; #1;
    checks++;
    if ({cpu_gnt1, dma_gnt1, rom_ce1, cpu_rvalid1, dma_rvalid1, rom_addr1, cpu_rdata1, dma_rdata1} !== 36'h0) begin
      errors++;
      $display("FAIL rmid_out1 got dv %b addr %h dd %h want 0", dma_rvalid1, rom_addr1, dma_rdata1);
    end
    checks++;
    if ({cpu_gnt3, dma_gnt3, rom_ce3, cpu_rvalid3, dma_rvalid3} !== 5'b00000) begin
      errors++;
      $display("FAIL rmid_out3 got %b want 00000", {cpu_gnt3, dma_gnt3, rom_ce3, cpu_rvalid3, dma_rvalid3});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({dma_rvalid1, dma_rvalid3, cpu_rvalid1, cpu_rvalid3} !== 4'b0000) begin
        errors++;
        $display("FAIL rmid_after[%0d] got %b want 0000", i, {dma_rvalid1, dma_rvalid3, cpu_rvalid1, cpu_rvalid3});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lat3();
    int          own [8] = '{1, 2, 1, 2, 0, 0, 0, 0};
    logic [14:0] adr [8] = '{15'h0010, 15'h4010, 15'h0011, 15'h4011, 15'h0, 15'h0, 15'h0, 15'h0};
    int          r;
    logic [17:0] exp_ret;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      cpu_req = (own[i] == 1); dma_req = (own[i] == 2);
      cpu_addr = adr[i]; dma_addr = adr[i]; #1;
      checks++;
      if ({cpu_gnt3, dma_gnt3, rom_ce3} !== {own[i] == 1, own[i] == 2, own[i] != 0}) begin
        errors++;
        $display("FAIL lat3_gnt[%0d] got %b want %b", i, {cpu_gnt3, dma_gnt3, rom_ce3}, {own[i] == 1, own[i] == 2, own[i] != 0});
      end
      r = (i >= 3) ? own[i-3] : 0;
      exp_ret = {r == 1, r == 2,
                 (r == 1) ? rom_f(adr[i-3 >= 0 ? i-3 : 0]) : 8'h00,
                 (r == 2) ? rom_f(adr[i-3 >= 0 ? i-3 : 0]) : 8'h00};
      checks++;
      if ({cpu_rvalid3, dma_rvalid3, cpu_rdata3, dma_rdata3} !== exp_ret) begin
        errors++;
        $display("FAIL lat3_ret[%0d] got %h want %h", i, {cpu_rvalid3, dma_rvalid3, cpu_rdata3, dma_rdata3}, exp_ret);
      end
    end
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; dma_req = 1'b0;
    cpu_addr = 15'h0; dma_addr = 15'h0;
    test_reset();
    test_cpu_single();
    test_contend();
    test_dma_stream();
    test_cpu_drop();
    test_reset_mid();
    test_lat3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cart_rom_arbiter.md
# cart_rom_arbiter

Shares the single-port cartridge ROM (`cart_prom`, registered output) between two requesters: the CPU fetch/read port of `dmg_main` and the OAM DMA engine. It arbitrates one read per cycle, drives the PROM address and clock enable, tracks in-flight reads through the PROM latency, and returns data to the owner with a valid strobe. It sits between `dmg_main` and `cart_prom` in `top`, replacing the direct `rom_addr`/`rom_data` connection.

## Interface

- `ADDR_W`, 15, ROM byte address width
- `DATA_W`, 8, ROM data width
- `ROM_LAT`, 1, PROM read latency in cycles (address sampled at edge to data valid); legal 1..4
- `MAX_WAIT`, 3, max consecutive cycles a pending CPU request may lose to DMA; legal 1..15

- `clk` in 1 — system clock (`tclk`); one clock; all logic on its rising edge
- `rst` in 1 — synchronous, active-high reset
- `cpu_req` in 1 — CPU read request; held with `cpu_addr` stable until `cpu_gnt`
- `cpu_addr` in ADDR_W — CPU read address
- `cpu_gnt` out 1 — CPU request accepted this cycle
- `cpu_rvalid` out 1 — `cpu_rdata` valid this cycle
- `cpu_rdata` out DATA_W — read data to CPU
- `dma_req`, `dma_addr`, `dma_gnt`, `dma_rvalid`, `dma_rdata` — identical semantics for the DMA port
- `rom_ce` out 1 — PROM clock enable; 1 only in grant cycles
- `rom_addr` out ADDR_W — PROM address
- `rom_data` in DATA_W — PROM registered output

## Operation

- Grant decision is combinational from `cpu_req`, `dma_req` and `wait_ctr`; at most one grant per cycle.
- Priority: DMA wins when both request, unless `wait_ctr == MAX_WAIT`, in which case CPU wins.
- `wait_ctr` (4 bits): increments each cycle `cpu_req && !cpu_gnt`; clears on `cpu_gnt` or `!cpu_req`; never exceeds MAX_WAIT.
- Grant cycle: `rom_ce=1`, `rom_addr` = winner's address (combinational mux), winner's `gnt=1`.
- Non-grant cycle: `rom_ce=0`, `rom_addr` holds the last granted address (registered copy).
- Owner tag pipeline, depth ROM_LAT, entries {OWN_NONE, OWN_CPU, OWN_DMA}; grant pushes owner, otherwise pushes OWN_NONE.
- Pipeline output selects the return port: that port's `rvalid=1`, `rdata=rom_data`. Non-owner `rdata` is 0; `rvalid` low means `rdata` is 0.
- Requester may drop `req` without a grant; no read issued, no later `rvalid`.
- Requests may be back-to-back; a requester may hold `req` continuously and receive one grant per winning cycle (streaming).

## Timing

- Reset (cycle of `rst=1` and the following edge): tag pipeline all OWN_NONE, `wait_ctr=0`, registered `rom_addr`=0. Outputs while `rst=1`: `cpu_gnt=dma_gnt=0`, `rom_ce=0`, both `rvalid=0`, both `rdata=0`.
- Reset mid-operation: in-flight reads are discarded; no `rvalid` in any cycle after `rst` deasserts for reads granted before it.
- Latency: grant in cycle N → `rvalid` in cycle N+ROM_LAT; throughput one read/cycle.
- Simultaneous requests with `wait_ctr<MAX_WAIT`: DMA granted, `wait_ctr` +1. At MAX_WAIT: CPU granted, counter clears next cycle.
- DMA streaming with CPU pending: CPU granted at most every MAX_WAIT+1 cycles.
- Single requester: granted in the first cycle `req` is seen (zero-cycle arbitration).

## Structure

- Shared package `dmg_pkg`: `typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} rom_owner_t`; default `ROM_ADDR_W=15`, `ROM_DATA_W=8`.
- One natural sub-module: `rom_tag_pipe` — parameterised ROM_LAT-deep shift register of `rom_owner_t` with synchronous clear.
- Arbitration, wait counter, address mux/hold and return demux in `cart_rom_arbiter`.

## Test plan

- Reset then CPU-only `cpu_addr=15'h0100` one cycle → `cpu_gnt` same cycle, `rom_addr=15'h0100`, `cpu_rvalid` one cycle later with PROM byte at 0x0100; `dma_rvalid` stays 0.
- Both request continuously (DMA 0x4000.., CPU 0x0150), MAX_WAIT=3 → grant pattern DMA,DMA,DMA,CPU repeating; each `rvalid` delivered to the matching port with correct byte.
- DMA streams 160 consecutive addresses 0x4000–0x409F → 160 grants in 160 cycles, 160 in-order `dma_rvalid` pulses.
- CPU asserts `req` two cycles while DMA streams, then drops → `wait_ctr` returns to 0, no `cpu_gnt`, no `cpu_rvalid`.
- `rst` asserted the cycle after a DMA grant → no `dma_rvalid` afterwards; all outputs 0 during reset.
- ROM_LAT=3 build, alternating grants → each `rvalid` exactly 3 cycles after its grant, owner order preserved.
